// File: rtl/div_ctrl_pkg.sv
// Shared widths, constants and state encoding for the EX-stage divide initiator.
package div_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  localparam logic [DATA_W-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [DATA_W-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'd0,
    DIV_WAIT    = 2'd1,
    DIV_CORRECT = 2'd2,
    DIV_DONE    = 2'd3
  } div_state_e;

  // INT_MIN / -1 cannot be represented; it takes the fixed special result.
  function automatic logic is_overflow(input logic [DATA_W-1:0] op1,
                                       input logic [DATA_W-1:0] op2);
    return (op1 == INT_MIN) && (op2 == ALL_ONES);
  endfunction

endpackage

// File: rtl/div_fixup.sv
// Sign correction of the raw divider output into truncating-division quotient/remainder.
module div_fixup
  import div_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] raw_rem,
  input  logic [DATA_W-1:0] raw_quo,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem,
  output logic [DATA_W-1:0] quo
);

  logic need_fix;
  logic same_sign;

  // A nonzero remainder must carry the dividend's sign.
  assign need_fix  = (raw_rem != '0) && (raw_rem[DATA_W-1] != dividend[DATA_W-1]);
  assign same_sign = (dividend[DATA_W-1] == divisor[DATA_W-1]);

  always_comb begin
    rem = raw_rem;
    quo = raw_quo;
    if (need_fix) begin
      if (same_sign) begin
        rem = raw_rem + divisor;
        quo = raw_quo - 1'b1;
      end else begin
        rem = raw_rem - divisor;
        quo = raw_quo + 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// EX-stage initiator for the combinational signed divider array: stalls EX, drives
// the array for DIV_CYCLES, then returns one corrected quotient or remainder.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_div_req,
  input  logic                  ex_is_rem,
  input  logic [DATA_W-1:0]     ex_op1,
  input  logic [DATA_W-1:0]     ex_op2,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  result_valid,
  output logic [DATA_W-1:0]     result,
  output logic                  div_en,
  output logic [DATA_W-1:0]     div_op1,
  output logic [DATA_W-1:0]     div_op2,
  input  logic                  div_done,
  input  logic [2*DATA_W-1:0]   div_result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_rem_q;
  logic [DATA_W-1:0] raw_rem_q, raw_quo_q;
  logic [DATA_W-1:0] fix_rem, fix_quo;
  logic              start;
  logic              special;
  logic              wait_exit;

  assign start     = ex_div_req && !flush;
  assign special   = (ex_op2 == '0) || is_overflow(ex_op1, ex_op2);
  assign wait_exit = div_done || (cnt_q == CNT_LAST);

  // DONE is the one cycle EX is allowed to advance with the result.
  assign stall_req = ex_div_req && (state_q != DIV_DONE) && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE:    if (start) state_d = special ? DIV_DONE : DIV_WAIT;
      DIV_WAIT:    if (wait_exit) state_d = DIV_CORRECT;
      DIV_CORRECT: state_d = DIV_DONE;
      DIV_DONE:    state_d = DIV_IDLE;
      default:     state_d = DIV_IDLE;
    endcase
    if (flush) state_d = DIV_IDLE;
  end

  div_fixup u_fixup (
    .raw_rem  (raw_rem_q),
    .raw_quo  (raw_quo_q),
    .dividend (div_op1),
    .divisor  (div_op2),
    .rem      (fix_rem),
    .quo      (fix_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DIV_IDLE;
      cnt_q        <= '0;
      is_rem_q     <= 1'b0;
      raw_rem_q    <= '0;
      raw_quo_q    <= '0;
      div_en       <= 1'b0;
      div_op1      <= '0;
      div_op2      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      result_valid <= (state_d == DIV_DONE);
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            div_op1  <= ex_op1;
            div_op2  <= ex_op2;
            is_rem_q <= ex_is_rem;
            if (ex_op2 == '0) begin
              result <= ex_is_rem ? ex_op1 : ALL_ONES;
            end else if (is_overflow(ex_op1, ex_op2)) begin
              result <= ex_is_rem ? '0 : INT_MIN;
            end else begin
              div_en <= 1'b1;
              cnt_q  <= '0;
            end
          end
        end
        DIV_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (wait_exit) begin
            raw_rem_q <= div_result[2*DATA_W-1:DATA_W];
            raw_quo_q <= div_result[DATA_W-1:0];
            div_en    <= 1'b0;
          end
        end
        DIV_CORRECT: begin
          if (!flush) result <= is_rem_q ? fix_rem : fix_quo;
        end
        default: ;
      endcase
      if (flush) div_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a behavioural divider array and a result scoreboard.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int DIV_CYCLES = 4;

  typedef logic [31:0] data_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_div_req;
  logic         ex_is_rem;
  data_t        ex_op1;
  data_t        ex_op2;
  logic         flush;
  logic         stall_req;
  logic         result_valid;
  data_t        result;
  logic         div_en;
  data_t        div_op1;
  data_t        div_op2;
  logic         div_done;
  logic [63:0]  div_result;

  logic         early_done = 1'b0;
  int           en_run = 0;
  int           dq, dr;

  data_t        fx_raw_rem, fx_raw_quo, fx_dividend, fx_divisor, fx_rem, fx_quo;

  int           n_pass = 0;
  int           n_total = 0;
  data_t        sb_q[$];

  typedef struct {
    data_t a;
    data_t b;
    logic  rem;
    data_t exp;
    int    lat;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  div_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_div_req   (ex_div_req),
    .ex_is_rem    (ex_is_rem),
    .ex_op1       (ex_op1),
    .ex_op2       (ex_op2),
    .flush        (flush),
    .stall_req    (stall_req),
    .result_valid (result_valid),
    .result       (result),
    .div_en       (div_en),
    .div_op1      (div_op1),
    .div_op2      (div_op2),
    .div_done     (div_done),
    .div_result   (div_result)
  );

  div_fixup u_fix (
    .raw_rem  (fx_raw_rem),
    .raw_quo  (fx_raw_quo),
    .dividend (fx_dividend),
    .divisor  (fx_divisor),
    .rem      (fx_rem),
    .quo      (fx_quo)
  );

  // Divider array model: floor-style raw output so the controller's correction matters;
  // output is garbage until div_en has been held long enough (unless it signals done).
  always @(posedge clk) begin
    if (div_en) en_run <= en_run + 1;
    else        en_run <= 0;
  end

  assign div_done = early_done & div_en;

  always_comb begin
    dq = 0;
    dr = 0;
    div_result = 64'hDEAD_BEEF_0BAD_F00D;
    if (div_op2 != 0 && !(div_op1 == 32'h8000_0000 && div_op2 == 32'hFFFF_FFFF)) begin
      dq = $signed(div_op1) / $signed(div_op2);
      dr = $signed(div_op1) % $signed(div_op2);
      if (dr != 0 && ((dr < 0) != ($signed(div_op2) < 0))) begin
        dq = dq - 1;
        dr = dr + $signed(div_op2);
      end
      if (early_done || en_run >= DIV_CYCLES - 1) div_result = {dr, dq};
    end
  end

  task automatic check(input string name, input data_t act, input data_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic data_t ref_div(input data_t a, input data_t b, input logic rem);
    int sa, sb;
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    sa = $signed(a);
    sb = $signed(b);
    return rem ? data_t'(sa % sb) : data_t'(sa / sb);
  endfunction

  always @(negedge clk) begin
    #1;
    if (result_valid) begin
      if (sb_q.size() == 0) check("unexpected_valid", data_t'(result_valid), 32'h0);
      else check("result", result, sb_q.pop_front());
    end
  end

  task automatic do_op(input data_t a, input data_t b, input logic rem,
                       input data_t exp, input int exp_lat);
    int  en_n, st_n;
    bit  seen;
    @(negedge clk);
    ex_div_req = 1'b1;
    ex_op1     = a;
    ex_op2     = b;
    ex_is_rem  = rem;
    sb_q.push_back(exp);
    seen = 0; en_n = 0; st_n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (result_valid) begin
        check("latency", data_t'(c), data_t'(exp_lat));
        check("stall_in_done", data_t'(stall_req), 32'h0);
        check("stall_cycles", data_t'(st_n), data_t'(exp_lat));
        check("div_en_cycles", data_t'(en_n), data_t'(exp_lat == 1 ? 0 : exp_lat - 2));
        seen = 1;
        break;
      end
      st_n += int'(stall_req);
      en_n += int'(div_en);
      @(negedge clk);
    end
    if (!seen) check("valid_timeout", data_t'(result_valid), 32'h1);
    ex_div_req = 1'b0;
  endtask

  task automatic fix_chk(input data_t rr, input data_t rq, input data_t dd, input data_t dv,
                         input data_t er, input data_t eq);
    fx_raw_rem = rr; fx_raw_quo = rq; fx_dividend = dd; fx_divisor = dv;
    #1;
    check("fix_rem", fx_rem, er);
    check("fix_quo", fx_quo, eq);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    data_t a, b;
    logic  r;
    rst = 1'b1; ex_div_req = 1'b0; ex_is_rem = 1'b0; ex_op1 = '0; ex_op2 = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_valid",  data_t'(result_valid), 32'h0);
    check("rst_div_en", data_t'(div_en), 32'h0);
    check("rst_op1",    div_op1, 32'h0);
    check("rst_op2",    div_op2, 32'h0);
    check("rst_result", result, 32'h0);
    rst = 1'b0;

    // div_fixup alone: both correction branches, pass-through, zero remainder
    fix_chk(32'hFFFF_FFFF, 32'd4,         32'd7,         32'd2,         32'd1,         32'd3);
    fix_chk(32'd1,         32'd4,         32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3);
    fix_chk(32'd1,         32'hFFFF_FFFC, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    fix_chk(32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    fix_chk(32'd1,         32'd3,         32'd7,         32'd2,         32'd1,         32'd3);
    fix_chk(32'd0,         32'd3,         32'd6,         32'd2,         32'd0,         32'd3);

    vecs.push_back('{32'd7,         32'd2,         1'b0, 32'd3,         6});
    vecs.push_back('{32'd7,         32'd2,         1'b1, 32'd1,         6});
    vecs.push_back('{32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFD, 6});
    vecs.push_back('{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF, 6});
    vecs.push_back('{32'd7,         32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 6});
    vecs.push_back('{32'd7,         32'hFFFF_FFFE, 1'b1, 32'd1,         6});
    vecs.push_back('{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 32'd3,         6});
    vecs.push_back('{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF, 6});
    vecs.push_back('{32'd7,         32'd0,         1'b0, 32'hFFFF_FFFF, 1});
    vecs.push_back('{32'd7,         32'd0,         1'b1, 32'd7,         1});
    vecs.push_back('{32'hFFFF_FFF8, 32'd0,         1'b1, 32'hFFFF_FFF8, 1});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0,         1});
    vecs.push_back('{32'h8000_0000, 32'd2,         1'b0, 32'hC000_0000, 6});
    vecs.push_back('{32'd100,       32'd7,         1'b1, 32'd2,         6});
    vecs.push_back('{32'd0,         32'd5,         1'b0, 32'd0,         6});
    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].rem, vecs[i].exp, vecs[i].lat);

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? data_t'($urandom_range(0, 9)) - 32'd4 : $urandom;
      r = 1'($urandom_range(0, 1));
      do_op(a, b, r, ref_div(a, b, r), (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 6);
    end

    // flush during WAIT cycle 2
    @(negedge clk);
    ex_div_req = 1'b1; ex_op1 = 32'd20; ex_op2 = 32'd3; ex_is_rem = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall", data_t'(stall_req), 32'h0);
    @(negedge clk);
    flush = 1'b0; ex_div_req = 1'b0;
    #1;
    check("flush_div_en", data_t'(div_en), 32'h0);
    check("flush_state", data_t'(dut.state_q), data_t'(DIV_IDLE));
    repeat (8) @(negedge clk);
    do_op(32'd9, 32'd3, 1'b0, 32'd3, 6);

    // reset while in CORRECT
    @(negedge clk);
    ex_div_req = 1'b1; ex_op1 = 32'd10; ex_op2 = 32'd3; ex_is_rem = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("pre_rst_state", data_t'(dut.state_q), data_t'(DIV_CORRECT));
    rst = 1'b1;
    @(negedge clk);
    ex_div_req = 1'b0;
    #1;
    check("mid_rst_valid",  data_t'(result_valid), 32'h0);
    check("mid_rst_div_en", data_t'(div_en), 32'h0);
    check("mid_rst_op1",    div_op1, 32'h0);
    check("mid_rst_op2",    div_op2, 32'h0);
    check("mid_rst_result", result, 32'h0);
    rst = 1'b0;

    // back-to-back, separated only by DONE
    do_op(32'd10, 32'd3, 1'b0, 32'd3, 6);
    do_op(32'd10, 32'd4, 1'b0, 32'd2, 6);

    // early completion from the array
    early_done = 1'b1;
    do_op(32'd100, 32'd7, 1'b0, 32'd14, 3);
    early_done = 1'b0;

    repeat (4) @(negedge clk);
    check("scoreboard_empty", data_t'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- EX-stage initiator for the combinational signed divider array.
- Accepts a signed DIV/REM request from the EX pipeline and stalls the pipeline while the divider settles.
- Drives the divider's div_en and operand inputs, then samples its {remainder, quotient} result.
- Applies sign correction and the RISC-V special cases; returns one 32-bit result for one cycle.

Parameters:
- DIV_CYCLES, 4, multicycle settle budget for the divider array (cycles div_en is held before sampling); legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- ex_div_req  input  1  EX holds a signed divide op; held high while stall_req is high
- ex_is_rem  input  1  1 = return remainder, 0 = return quotient
- ex_op1  input  `DATA_BUS  dividend
- ex_op2  input  `DATA_BUS  divisor
- flush  input  1  pipeline flush; cancels any op in flight
- stall_req  output  1  freeze EX and earlier stages
- result_valid  output  1  result valid; one-cycle pulse
- result  output  `DATA_BUS  selected quotient or remainder
- div_en  output  1  enable to divider array
- div_op1  output  `DATA_BUS  dividend to divider
- div_op2  output  `DATA_BUS  divisor to divider
- div_done  input  1  optional early-completion flag from divider; may be tied 0
- div_result  input  `DOUBLE_DATA_BUS  divider output, {raw_rem, raw_quo}

Behaviour:
- One clock. Reset is synchronous and active-high: clk, rst.
- Reset values: state=IDLE; div_en=0, div_op1=0, div_op2=0, result=0, result_valid=0; counter=0.
- stall_req = ex_div_req & (state != DONE) & ~flush. Combinational, so EX freezes in the same cycle the request appears.

FSM states: IDLE, WAIT, CORRECT, DONE.
- IDLE, ex_div_req & ~flush:
  - Latch operands into div_op1/div_op2, latch is_rem.
  - If op2==0: latch special result, go to DONE.
  - Else if op1==0x80000000 and op2==0xFFFFFFFF: latch special result, go to DONE.
  - Else: div_en<=1, counter<=0, go to WAIT.
- WAIT:
  - div_en held 1; operands held stable; counter increments.
  - Leave when div_done==1 or counter==DIV_CYCLES-1: sample div_result into raw_rem/raw_quo, div_en<=0, go to CORRECT.
- CORRECT:
  - If raw_rem!=0 and sign(raw_rem)!=sign(dividend):
    - Dividend and divisor signs equal: rem=raw_rem+divisor, quo=raw_quo-1.
    - Signs differ: rem=raw_rem-divisor, quo=raw_quo+1.
  - Else pass raw_rem/raw_quo through.
  - Register the selected value into result; go to DONE.
- DONE: result_valid=1 for exactly this cycle; stall_req=0 so the pipeline advances; go to IDLE.
- Required final semantics (truncating division):
  - dividend = quo*divisor + rem, with |rem| < |divisor|.
  - rem is 0 or has the dividend's sign.
- Special results:
  - Divide by zero: quo=0xFFFFFFFF, rem=dividend.
  - Overflow (0x80000000 / -1): quo=0x80000000, rem=0.
- Latency:
  - Normal path: result_valid in cycle DIV_CYCLES+2 after the request cycle (less if div_done arrives early).
  - Special cases: result_valid 1 cycle after the request; div_en never asserted.
- Back-to-back: a request visible in the cycle after DONE is a new instruction and starts normally; no bubble is required beyond DONE.
- Flush has priority over everything in every state:
  - Next state is IDLE; div_en<=0; result_valid<=0; stall_req=0 immediately.
  - Any captured result is discarded.
- rst mid-operation: full return to reset values on the next edge; no result_valid is produced.
- All arithmetic is 32-bit two's complement; wrap-around is allowed in quo±1.

Decomposition:
- Add to bus.v:
  - state encoding macros DIV_IDLE/DIV_WAIT/DIV_CORRECT/DIV_DONE (2-bit);
  - `DIV_CNT_BUS for the counter;
  - constants INT_MIN (0x80000000) and ALL_ONES.
- One natural sub-module: div_fixup, purely combinational. It maps {raw_rem, raw_quo, dividend, divisor} to corrected {rem, quo}, so it can be verified alone against a reference model.
- The divider array itself is instantiated outside this block, at EX-stage top level.

Test Plan:
- 7/2, quotient, DIV_CYCLES=4: stall_req high 6 cycles; div_en high 4 cycles; result=3, result_valid pulse at cycle 6. Same with ex_is_rem=1: result=1.
- -7 (0xFFFFFFF9) / 2: quotient 0xFFFFFFFD; remainder 0xFFFFFFFF. 7 / -2: quotient 0xFFFFFFFD, remainder 1. Cover both correction branches with a forced raw_rem in the div_fixup unit test.
- 7/0: div_en never asserted; result_valid at cycle 1 with quotient 0xFFFFFFFF, or remainder 7 when ex_is_rem=1.
- 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, 1-cycle latency, div_en stays 0.
- flush asserted in WAIT cycle 2: stall_req drops that cycle; div_en 0 and state IDLE next cycle; no result_valid. A following 9/3 request yields 3 normally.
- rst asserted in CORRECT: all outputs at reset values after the edge; no result_valid. Back-to-back 10/3 then 10/4 produce 3 then 2, separated only by the DONE cycle.
